// File: rtl/shift_seq_32_pkg.sv
// Shared encodings for the multi-cycle shift sequencer: shift ops and FSM states.
package shift_seq_32_pkg;

    localparam int WIDTH = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_RSV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/shift_seq_32_if.sv
// Request/response bundle between ALU control (master) and the shift sequencer (slave).
interface shift_seq_32_if;
    import shift_seq_32_pkg::*;

    logic                 start;
    logic [1:0]           op;
    logic [WIDTH-1:0]     rt;
    logic [SHAMT_W-1:0]   shamt;
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     rd;

    modport master (
        output start, op, rt, shamt,
        input  busy, done, rd
    );

    modport slave (
        input  start, op, rt, shamt,
        output busy, done, rd
    );
endinterface

// File: rtl/shift_seq_32_step.sv
// Narrow shifter: moves acc by k (0..STEP) bits with the fill selected by op.
module shift_step_32
    import shift_seq_32_pkg::*;
#(
    parameter int STEP = 4,
    parameter int KW   = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [1:0]       op_i,
    input  logic [KW-1:0]    k_i,
    output logic [WIDTH-1:0] res_o
);

    logic [WIDTH-1:0] cand [0:STEP];

    // One constant-distance candidate per legal k; the mux below picks one.
    for (genvar gi = 0; gi <= STEP; gi++) begin : g_cand
        assign cand[gi] = (op_i == SH_SLL) ? (acc_i << gi) :
                          (op_i == SH_SRL) ? (acc_i >> gi) :
                          (op_i == SH_SRA) ? WIDTH'($signed(acc_i) >>> gi) :
                                             acc_i;
    end

    always_comb begin
        res_o = acc_i;
        for (int i = 0; i <= STEP; i++) begin
            if (k_i == KW'(i)) begin
                res_o = cand[i];
            end
        end
    end

endmodule

// File: rtl/shift_seq_32.sv
// Multi-cycle sll/srl/sra sequencer: iterates a STEP-bit shifter until shamt is consumed.
module shift_seq_32
    import shift_seq_32_pkg::*;
#(
    parameter int STEP = 4
) (
    input  logic          clk,
    input  logic          rst,
    shift_seq_32_if.slave bus
);

    localparam int KW = $clog2(STEP + 1);
    localparam logic [KW-1:0] STEP_K = KW'(STEP);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     rd_q, rd_d;
    logic [SHAMT_W-1:0]   rem_q, rem_d;
    logic [1:0]           op_q, op_d;

    logic [KW-1:0]        k;
    logic [SHAMT_W-1:0]   k_ext;
    logic [WIDTH-1:0]     acc_sh;

    // Clamping k to rem keeps rem from ever wrapping below zero.
    always_comb begin
        if (rem_q < SHAMT_W'(STEP)) begin
            k = KW'(rem_q);
        end else begin
            k = STEP_K;
        end
        k_ext = SHAMT_W'(k);
    end

    shift_step_32 #(
        .STEP (STEP),
        .KW   (KW)
    ) u_step (
        .acc_i (acc_q),
        .op_i  (op_q),
        .k_i   (k),
        .res_o (acc_sh)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            rd_q    <= '0;
            rem_q   <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rd_q    <= rd_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rd_d    = rd_q;
        rem_d   = rem_q;
        op_d    = op_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    acc_d = bus.rt;
                    rem_d = bus.shamt;
                    op_d  = bus.op;
                    // Zero shift and the reserved op bypass the iteration entirely.
                    if (bus.shamt == '0 || bus.op == SH_RSV) begin
                        rd_d    = bus.rt;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                acc_d = acc_sh;
                rem_d = rem_q - k_ext;
                if (rem_q == k_ext) begin
                    rd_d    = acc_sh;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.busy = (state_q != ST_IDLE);
    assign bus.done = (state_q == ST_DONE);
    assign bus.rd   = rd_q;

endmodule

// File: tb/tb_shift_seq_32.sv
// Directed bench for shift_seq_32: vector table plus hand-written overlap and reset sequences.
module tb_shift_seq_32;
    import shift_seq_32_pkg::*;

    logic clk;
    logic rst;

    shift_seq_32_if bus ();

    shift_seq_32 #(.STEP(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rt;
        logic [4:0]  shamt;
        logic [31:0] exp_rd;
        int          exp_n;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Issue one request at a negedge, scramble inputs after the start edge, and count cycles to done.
    task automatic run_op(input int idx, input logic [1:0] op, input logic [31:0] rt,
                          input logic [4:0] shamt, input logic [31:0] exp_rd, input int exp_n);
        int cyc;
        int busy_bad;
        cyc = 0;
        busy_bad = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.rt    = rt;
        bus.shamt = shamt;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.rt    = ~rt;
        bus.shamt = shamt + 5'd3;
        bus.op    = op ^ 2'b01;
        do begin
            @(negedge clk);
            cyc++;
            if (bus.busy !== 1'b1) busy_bad++;
        end while (bus.done !== 1'b1 && cyc < 20);
        check_int($sformatf("vec%0d latency", idx), cyc, exp_n);
        check32($sformatf("vec%0d rd", idx), bus.rd, exp_rd);
        check_int($sformatf("vec%0d busy_drops", idx), busy_bad, 0);
        @(negedge clk);
        check_int($sformatf("vec%0d done_one_cycle", idx), int'(bus.done), 0);
        $display("vec%0d op=%0d rt=0x%08h shamt=%0d -> rd=0x%08h after %0d cycles",
                 idx, op, rt, shamt, bus.rd, cyc);
    endtask

    initial begin
        int cyc;
        int done_cnt;
        int done_cyc;
        logic [31:0] done_rd;
        int idle_bad;

        vecs[0]  = '{SH_SRL, 32'h805C9BD2, 5'd5,  32'h0402E4DE, 3};
        vecs[1]  = '{SH_SRA, 32'h805C9BD2, 5'd5,  32'hFC02E4DE, 3};
        vecs[2]  = '{SH_SLL, 32'h805C9BD2, 5'd4,  32'h05C9BD20, 2};
        vecs[3]  = '{SH_SLL, 32'h805C9BD2, 5'd31, 32'h00000000, 9};
        vecs[4]  = '{SH_SRL, 32'h805C9BD2, 5'd31, 32'h00000001, 9};
        vecs[5]  = '{SH_SRA, 32'h805C9BD2, 5'd31, 32'hFFFFFFFF, 9};
        vecs[6]  = '{SH_SLL, 32'h805C9BD2, 5'd0,  32'h805C9BD2, 1};
        vecs[7]  = '{SH_SRL, 32'h805C9BD2, 5'd0,  32'h805C9BD2, 1};
        vecs[8]  = '{SH_SRA, 32'h805C9BD2, 5'd0,  32'h805C9BD2, 1};
        vecs[9]  = '{SH_RSV, 32'h805C9BD2, 5'd7,  32'h805C9BD2, 1};
        vecs[10] = '{SH_SRA, 32'h70000000, 5'd8,  32'h00700000, 3};
        vecs[11] = '{SH_SRL, 32'hFFFFFFFF, 5'd1,  32'h7FFFFFFF, 2};
        vecs[12] = '{SH_SLL, 32'h00000001, 5'd17, 32'h00020000, 6};
        vecs[13] = '{SH_SRA, 32'h80000000, 5'd3,  32'hF0000000, 2};
        vecs[14] = '{SH_SRL, 32'h805C9BD2, 5'd8,  32'h00805C9B, 3};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.rt    = 32'hDEADBEEF;
        bus.shamt = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        check_int("reset busy", int'(bus.busy), 0);
        check_int("reset done", int'(bus.done), 0);
        check32("reset rd", bus.rd, 32'h0);
        idle_bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rd !== 32'h0) idle_bad++;
        end
        check_int("idle no change", idle_bad, 0);
        $display("reset/idle: busy=%0b done=%0b rd=0x%08h", bus.busy, bus.done, bus.rd);

        for (int i = 0; i < NVEC; i++) begin
            run_op(i, vecs[i].op, vecs[i].rt, vecs[i].shamt, vecs[i].exp_rd, vecs[i].exp_n);
        end

        // A second start during RUN must be ignored.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = SH_SRL;
        bus.rt    = 32'h805C9BD2;
        bus.shamt = 5'd31;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        done_cnt = 0;
        done_cyc = 0;
        done_rd  = 32'h0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 2) begin
                bus.start = 1'b1;
                bus.rt    = 32'hFFFFFFFF;
                bus.shamt = 5'd1;
            end else begin
                bus.start = 1'b0;
                bus.rt    = 32'h12345678;
            end
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_cyc == 0) begin
                    done_cyc = c;
                    done_rd  = bus.rd;
                end
            end
        end
        bus.start = 1'b0;
        check_int("overlap latency", done_cyc, 9);
        check32("overlap rd", done_rd, 32'h00000001);
        check_int("overlap done pulses", done_cnt, 1);
        $display("overlap: done at cycle %0d rd=0x%08h pulses=%0d", done_cyc, done_rd, done_cnt);

        // Reset in the middle of RUN aborts the operation.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = SH_SRA;
        bus.rt    = 32'h805C9BD2;
        bus.shamt = 5'd31;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc = 0;
        repeat (4) begin
            @(negedge clk);
            cyc++;
        end
        check_int("pre-abort busy", int'(bus.busy), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_int("abort busy", int'(bus.busy), 0);
        check32("abort rd", bus.rd, 32'h0);
        done_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_cnt++;
        end
        check_int("abort no done", done_cnt, 0);
        $display("abort: busy=%0b rd=0x%08h done pulses after abort=%0d", bus.busy, bus.rd, done_cnt);

        run_op(100, SH_SRL, 32'h805C9BD2, 5'd5, 32'h0402E4DE, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
